// File: rtl/program_loader.sv
// program_loader
//
// Host-side writer for the sequencer's 80-bit instruction memory. A framed
// byte stream (valid/ready) carries START / WORD / END commands. Each WORD
// frame brings WORD_BYTES data bytes (most significant byte first) followed
// by one XOR checksum byte. Verified words are written to consecutive
// addresses starting at 0. While a session is open, `loading` holds the
// sequencer off.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high, clears all state
//   rx_data      incoming byte
//   rx_valid     rx_data is valid
//   rx_ready     byte accepted on an edge where rx_valid & rx_ready
//   mem_address  instruction memory write address
//   mem_wdata    instruction memory write data
//   mem_we       one-cycle write strobe
//   loading      a load session is open
//   load_done    last session was closed cleanly by END
//   error        sticky: [0] bad command, [1] checksum mismatch, [2] overflow
//   word_count   words written in the current session

module program_loader #(
    parameter int ADDR_WIDTH = 15,
    parameter int WORD_BYTES = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    mem_we,
    output logic                    loading,
    output logic                    load_done,
    output logic [2:0]              error,
    output logic [ADDR_WIDTH:0]     word_count
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int CNT_W  = $clog2(WORD_BYTES + 1);

    localparam logic [7:0] CMD_START = 8'hA5;
    localparam logic [7:0] CMD_WORD  = 8'h5A;
    localparam logic [7:0] CMD_END   = 8'hC3;

    localparam logic [CNT_W-1:0]    LAST_BYTE  = CNT_W'(WORD_BYTES - 1);
    // Memory is full once every address has been written exactly once.
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CSUM,
        S_WRITE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]              csum_q, csum_d;
    logic [WORD_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
    logic                    loading_q, loading_d;
    logic                    load_done_q, load_done_d;
    logic [2:0]              error_q, error_d;
    logic                    mem_we_q, mem_we_d;
    logic                    rx_ready_q, rx_ready_d;
    logic                    accept;
    logic                    full;

    assign accept = rx_valid && rx_ready_q;
    assign full   = (word_count_q == FULL_COUNT);

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        csum_d        = csum_q;
        mem_wdata_d   = mem_wdata_q;
        mem_address_d = mem_address_q;
        word_count_d  = word_count_q;
        loading_d     = loading_q;
        load_done_d   = load_done_q;
        error_d       = error_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (rx_data)
                        CMD_START: begin
                            mem_address_d = '0;
                            word_count_d  = '0;
                            error_d       = '0;
                            load_done_d   = 1'b0;
                            loading_d     = 1'b1;
                        end
                        CMD_WORD: begin
                            if (loading_q) begin
                                state_d    = S_DATA;
                                byte_cnt_d = '0;
                                csum_d     = '0;
                            end else begin
                                error_d[0] = 1'b1;
                            end
                        end
                        CMD_END: begin
                            if (loading_q) begin
                                loading_d   = 1'b0;
                                load_done_d = 1'b1;
                            end else begin
                                error_d[0] = 1'b1;
                            end
                        end
                        default: error_d[0] = 1'b1;
                    endcase
                end
            end

            S_DATA: begin
                if (accept) begin
                    // First byte ends up in the top byte after WORD_BYTES shifts.
                    mem_wdata_d = {mem_wdata_q[WORD_W-9:0], rx_data};
                    csum_d      = csum_q ^ rx_data;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = S_CSUM;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

            S_CSUM: begin
                // A full memory still consumes the whole frame so framing
                // stays intact; the word is simply dropped.
                if (accept) begin
                    state_d = S_IDLE;
                    if (rx_data != csum_q) begin
                        error_d[1] = 1'b1;
                    end
                    if (full) begin
                        error_d[2] = 1'b1;
                    end
                    if ((rx_data == csum_q) && !full) begin
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                // Address wraps naturally after the last location.
                state_d       = S_IDLE;
                mem_address_d = mem_address_q + 1'b1;
                word_count_d  = word_count_q + 1'b1;
            end

            default: state_d = S_IDLE;
        endcase

        mem_we_d   = (state_d == S_WRITE);
        rx_ready_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            byte_cnt_q    <= '0;
            csum_q        <= '0;
            mem_wdata_q   <= '0;
            mem_address_q <= '0;
            word_count_q  <= '0;
            loading_q     <= 1'b0;
            load_done_q   <= 1'b0;
            error_q       <= '0;
            mem_we_q      <= 1'b0;
            rx_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            csum_q        <= csum_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_address_q <= mem_address_d;
            word_count_q  <= word_count_d;
            loading_q     <= loading_d;
            load_done_q   <= load_done_d;
            error_q       <= error_d;
            mem_we_q      <= mem_we_d;
            rx_ready_q    <= rx_ready_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign loading     = loading_q;
    assign load_done   = load_done_q;
    assign error       = error_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//
// Directed bench for program_loader. A full-size instance covers normal
// loading; a second instance with ADDR_WIDTH=2 covers memory overflow.
// Both share the byte stream; the bench handshakes against whichever
// instance is currently selected.

module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        sel_small = 1'b0;

    logic        rx_ready;
    logic [14:0] mem_address;
    logic [79:0] mem_wdata;
    logic        mem_we;
    logic        loading;
    logic        load_done;
    logic [2:0]  error;
    logic [15:0] word_count;

    logic        s_rx_ready;
    logic [1:0]  s_mem_address;
    logic [79:0] s_mem_wdata;
    logic        s_mem_we;
    logic        s_loading;
    logic        s_load_done;
    logic [2:0]  s_error;
    logic [2:0]  s_word_count;

    int checks = 0;
    int failures = 0;

    // Write monitors: every strobe is logged for later comparison.
    int          wr_n = 0;
    logic [14:0] wr_addr [0:255];
    logic [79:0] wr_data [0:255];
    int          sm_n = 0;
    logic [1:0]  sm_addr [0:255];

    always #5 clk = ~clk;

    program_loader u_dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .loading(loading), .load_done(load_done),
        .error(error), .word_count(word_count)
    );

    program_loader #(.ADDR_WIDTH(2), .WORD_BYTES(10)) u_small (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(s_rx_ready), .mem_address(s_mem_address), .mem_wdata(s_mem_wdata),
        .mem_we(s_mem_we), .loading(s_loading), .load_done(s_load_done),
        .error(s_error), .word_count(s_word_count)
    );

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_n < 256) begin
                wr_addr[wr_n] = mem_address;
                wr_data[wr_n] = mem_wdata;
            end
            wr_n = wr_n + 1;
        end
        if (s_mem_we) begin
            if (sm_n < 256) sm_addr[sm_n] = s_mem_address;
            sm_n = sm_n + 1;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Presents one byte after an optional idle gap and returns just after
    // the edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waits;
        logic rdy;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        waits = 0;
        rdy = sel_small ? s_rx_ready : rx_ready;
        while (!rdy && waits < 50) begin
            @(negedge clk);
            waits++;
            rdy = sel_small ? s_rx_ready : rx_ready;
        end
        if (!rdy) begin
            checks++;
            failures++;
            $display("[TB] FAIL handshake_timeout: rx_ready=%b required=1", rdy);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [79:0] w, input logic corrupt, input int maxgap);
        logic [7:0] cs;
        cs = 8'h00;
        send_byte(8'h5A, $urandom_range(0, maxgap));
        for (int i = 9; i >= 0; i--) begin
            cs = cs ^ w[8*i +: 8];
            send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
        end
        send_byte(corrupt ? (cs ^ 8'h01) : cs, $urandom_range(0, maxgap));
    endtask

    task automatic test_reset();
        do_reset();
        if ({rx_ready, mem_we, loading, load_done, error, word_count, mem_address}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0, 15'd0}) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got rdy=%b we=%b ld=%b done=%b err=%b wc=%0d addr=%0d required 1 0 0 0 000 0 0",
                     rx_ready, mem_we, loading, load_done, error, word_count, mem_address);
        end
        checks++;
        if (mem_wdata !== 80'h0) begin
            failures++;
            $display("[TB] FAIL reset_wdata: got %h required 0", mem_wdata);
        end
        checks++;
    endtask

    task automatic test_clean_load();
        int base;
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 0);
        @(negedge clk);
        if ({loading, error} !== {1'b1, 3'b000}) begin
            failures++;
            $display("[TB] FAIL start_loading: got ld=%b err=%b required 1 000", loading, error);
        end
        checks++;
        send_word(80'hFFFFFF00000000000007, 1'b0, 0);
        @(negedge clk);
        if ({mem_we, mem_address, mem_wdata} !== {1'b1, 15'd0, 80'hFFFFFF00000000000007}) begin
            failures++;
            $display("[TB] FAIL write_cycle: got we=%b addr=%0d data=%h required 1 0 ffffff00000000000007",
                     mem_we, mem_address, mem_wdata);
        end
        checks++;
        @(negedge clk);
        if ({mem_we, word_count, mem_address, rx_ready} !== {1'b0, 16'd1, 15'd1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL after_write: got we=%b wc=%0d addr=%0d rdy=%b required 0 1 1 1",
                     mem_we, word_count, mem_address, rx_ready);
        end
        checks++;
        send_byte(8'hC3, 0);
        @(negedge clk);
        if ({loading, load_done, error, word_count} !== {1'b0, 1'b1, 3'b000, 16'd1}) begin
            failures++;
            $display("[TB] FAIL end_session: got ld=%b done=%b err=%b wc=%0d required 0 1 000 1",
                     loading, load_done, error, word_count);
        end
        checks++;
        if (wr_n - base !== 1) begin
            failures++;
            $display("[TB] FAIL clean_write_count: got %0d required 1", wr_n - base);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int base;
        logic [79:0] refw [0:9];
        do_reset();
        base = wr_n;
        for (int i = 0; i < 10; i++) refw[i] = {$urandom, $urandom, $urandom};
        send_byte(8'hA5, 1);
        for (int i = 0; i < 10; i++) send_word(refw[i], 1'b0, 2);
        send_byte(8'hC3, 1);
        repeat (3) @(negedge clk);
        if (wr_n - base !== 10) begin
            failures++;
            $display("[TB] FAIL b2b_write_count: got %0d required 10", wr_n - base);
        end
        checks++;
        for (int i = 0; i < 10; i++) begin
            if ({wr_addr[base+i], wr_data[base+i]} !== {15'(i), refw[i]}) begin
                failures++;
                $display("[TB] FAIL b2b_word%0d: got addr=%0d data=%h required addr=%0d data=%h",
                         i, wr_addr[base+i], wr_data[base+i], i, refw[i]);
            end
            checks++;
        end
        if ({word_count, error, load_done} !== {16'd10, 3'b000, 1'b1}) begin
            failures++;
            $display("[TB] FAIL b2b_status: got wc=%0d err=%b done=%b required 10 000 1",
                     word_count, error, load_done);
        end
        checks++;
    endtask

    task automatic test_bad_checksum();
        int base;
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 0);
        send_word(80'h11223344556677889900, 1'b0, 0);
        send_word(80'hAABBCCDDEEFF01020304, 1'b1, 0);
        send_word(80'h0F0E0D0C0B0A09080706, 1'b0, 0);
        repeat (3) @(negedge clk);
        if (wr_n - base !== 2) begin
            failures++;
            $display("[TB] FAIL csum_write_count: got %0d required 2", wr_n - base);
        end
        checks++;
        if ({wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]}
            !== {15'd0, 80'h11223344556677889900, 15'd1, 80'h0F0E0D0C0B0A09080706}) begin
            failures++;
            $display("[TB] FAIL csum_writes: got a0=%0d d0=%h a1=%0d d1=%h required 0 112233... 1 0f0e0d...",
                     wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
        end
        checks++;
        if ({error, word_count, mem_address} !== {3'b010, 16'd2, 15'd2}) begin
            failures++;
            $display("[TB] FAIL csum_status: got err=%b wc=%0d addr=%0d required 010 2 2",
                     error, word_count, mem_address);
        end
        checks++;
    endtask

    task automatic test_outside_session();
        int base;
        do_reset();
        base = wr_n;
        send_byte(8'h5A, 0);
        @(negedge clk);
        if ({error, loading, rx_ready} !== {3'b001, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL stray_word: got err=%b ld=%b rdy=%b required 001 0 1", error, loading, rx_ready);
        end
        checks++;
        send_byte(8'hC3, 0);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        if ({error, loading, load_done, wr_n - base} !== {3'b001, 1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("[TB] FAIL stray_cmds: got err=%b ld=%b done=%b writes=%0d required 001 0 0 0",
                     error, loading, load_done, wr_n - base);
        end
        checks++;
        send_byte(8'hA5, 0);
        @(negedge clk);
        if ({error, loading} !== {3'b000, 1'b1}) begin
            failures++;
            $display("[TB] FAIL start_clears_error: got err=%b ld=%b required 000 1", error, loading);
        end
        checks++;
        send_word(80'h0123456789ABCDEF0246, 1'b0, 1);
        repeat (3) @(negedge clk);
        if ({wr_n - base, wr_addr[base], wr_data[base]} !== {32'd1, 15'd0, 80'h0123456789ABCDEF0246}) begin
            failures++;
            $display("[TB] FAIL post_stray_load: got writes=%0d addr=%0d data=%h required 1 0 0123456789abcdef0246",
                     wr_n - base, wr_addr[base], wr_data[base]);
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        int base;
        do_reset();
        base = wr_n;
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        if ({rx_ready, mem_we, loading, load_done, error, word_count, mem_address, mem_wdata}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 16'd0, 15'd0, 80'h0}) begin
            failures++;
            $display("[TB] FAIL midframe_reset: got rdy=%b we=%b ld=%b done=%b err=%b wc=%0d addr=%0d data=%h required reset values",
                     rx_ready, mem_we, loading, load_done, error, word_count, mem_address, mem_wdata);
        end
        checks++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        if (wr_n - base !== 0) begin
            failures++;
            $display("[TB] FAIL midframe_no_write: got %0d required 0", wr_n - base);
        end
        checks++;
        send_byte(8'hA5, 0);
        send_word(80'hDEADBEEF00C0FFEE1234, 1'b0, 0);
        repeat (3) @(negedge clk);
        if ({wr_n - base, wr_addr[base], wr_data[base], word_count}
            !== {32'd1, 15'd0, 80'hDEADBEEF00C0FFEE1234, 16'd1}) begin
            failures++;
            $display("[TB] FAIL midframe_reload: got writes=%0d addr=%0d data=%h wc=%0d required 1 0 deadbeef00c0ffee1234 1",
                     wr_n - base, wr_addr[base], wr_data[base], word_count);
        end
        checks++;
    endtask

    task automatic test_overflow();
        int base;
        sel_small = 1'b1;
        do_reset();
        base = sm_n;
        send_byte(8'hA5, 0);
        for (int i = 0; i < 5; i++) send_word({8'(i), 72'h55AA_1234_5678_9ABC_DE}, 1'b0, 0);
        repeat (3) @(negedge clk);
        if (sm_n - base !== 4) begin
            failures++;
            $display("[TB] FAIL ovf_write_count: got %0d required 4", sm_n - base);
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            if (sm_addr[base+i] !== 2'(i)) begin
                failures++;
                $display("[TB] FAIL ovf_addr%0d: got %0d required %0d", i, sm_addr[base+i], i);
            end
            checks++;
        end
        if ({s_error, s_word_count, s_mem_address, s_rx_ready} !== {3'b100, 3'd4, 2'd0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL ovf_status: got err=%b wc=%0d addr=%0d rdy=%b required 100 4 0 1",
                     s_error, s_word_count, s_mem_address, s_rx_ready);
        end
        checks++;
        sel_small = 1'b0;
    endtask

    initial begin
        $display("[TB] program_loader bench start");
        test_reset();
        test_clean_load();
        test_back_to_back();
        test_bad_checksum();
        test_outside_session();
        test_reset_midframe();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
